// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: holds the PC, reads a combinational instruction
// memory every cycle and buffers {pc, instr} pairs in a small FIFO for decode.
module ifetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [31:0]              iaddr,
    input  logic [31:0]              idata,
    input  logic                     fetch_en,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pc;
    logic [31:0]   store_pc    [DEPTH];
    logic [31:0]   store_instr [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          pop;
    logic          push;

    // A full queue may still accept a word when the head leaves in the same cycle.
    assign full      = (count == CW'(DEPTH));
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign push      = fetch_en & ~redirect & (~full | pop);

    assign iaddr     = pc;
    assign out_instr = store_instr[rd_ptr];
    assign out_pc    = store_pc[rd_ptr];
    assign q_count   = count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= {RESET_PC[31:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            pc     <= {redirect_pc[31:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                pc     <= pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // NOTE: the storage is reset only so the head reads as zero after reset;
    // a redirect leaves stale data behind, which is harmless because
    // out_valid is low until a new word is written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                store_pc[i]    <= '0;
                store_instr[i] <= '0;
            end
        end else if (push) begin
            store_pc[wr_ptr]    <= pc;
            store_instr[wr_ptr] <= idata;
        end
    end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
Instruction-fetch front end that drives the instruction memory read port. It holds the PC, presents a byte address to the combinational instruction memory each cycle, and captures the returned word into a small FIFO. The FIFO feeds decode through a valid/ready handshake. Decode/execute can redirect fetch on a branch or jump, and the redirect flushes the queue.

Parameters:
RESET_PC, 32'h0000_0000, byte address fetched first after reset; bits [1:0] must be 0.
DEPTH, 4, number of queue entries; power of two, 2..16.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
iaddr  output  32  byte address to instruction memory; equals pc register (word-aligned).
idata  input  32  instruction word returned combinationally for iaddr in the same cycle.
fetch_en  input  1  1 = fetch allowed; 0 = hold pc, no enqueue.
redirect  input  1  branch/jump taken; flush queue and load redirect_pc.
redirect_pc  input  32  new fetch address; bits [1:0] forced to 0 internally.
out_valid  output  1  queue head holds a valid instruction.
out_ready  input  1  decode accepts head this cycle.
out_instr  output  32  instruction at queue head.
out_pc  output  32  byte address of out_instr.
q_count  output  $clog2(DEPTH)+1  current occupancy (debug/verification).

Behaviour:
- Reset (sync, cycle of reset=1 at edge): pc<=RESET_PC; rd/wr pointers<=0; count<=0. After reset: out_valid=0, q_count=0, iaddr=RESET_PC, out_instr/out_pc=0 (head storage cleared).
- Reset overrides redirect, fetch_en, and handshake in the same cycle. Reset mid-stream discards all queued entries.
- iaddr = pc continuously. Memory is combinational, so the word is available in the same cycle.
- pop = out_valid & out_ready.
- push = fetch_en & ~redirect & (count<DEPTH | pop).
  - Full with simultaneous pop: push is allowed and count is unchanged.
- On push: store {pc, idata} at wr pointer; pc<=pc+4 (32-bit wrap, 0xFFFF_FFFC -> 0x0).
- On pop: advance rd pointer.
- Count update: count += push - pop. Pointers wrap modulo DEPTH.
- Latency: a word fetched in cycle N is visible as head (out_valid=1) in cycle N+1 when the queue was empty.
- Redirect (no reset): at the edge, count<=0, pointers<=0, pc<={redirect_pc[31:2],2'b00}.
  - No push that cycle. A pop handshake in the redirect cycle is still accepted by decode, but the entry is discarded with the flush.
  - out_valid=0 the cycle after redirect. The target instruction is the head two cycles after redirect.
- fetch_en=0: pc frozen and no push. Pops continue and the queue drains normally.
- out_instr/out_pc are driven from head storage and are stable while out_valid=1 & out_ready=0.
- out_valid = (count!=0).
- No combinational path from out_ready to out_valid. A combinational path from out_ready to push (via full-with-pop) is permitted.
- Implementation scope: pc register, DEPTH x 64-bit storage, pointers, counter, control logic. No FSM beyond the occupancy counter.

Test Plan:
- Reset, fetch_en=1, out_ready=1, memory word k = 0x1000_0000+k:
  - iaddr sequence is 0,4,8,...
  - out_valid rises 1 cycle after reset release.
  - out_pc/out_instr stream (0,0x1000_0000), (4,0x1000_0001), ... with no gaps and q_count=1 steady.
- out_ready=0 for 10 cycles, DEPTH=4:
  - q_count reaches 4 after 4 cycles, then pc holds at 0x10.
  - out_instr stays 0x1000_0000.
  - Then out_ready=1: entries 0,4,8,C drain in order, and 0x10 follows without loss or duplicate.
- Full queue, out_ready=1 same cycle as push:
  - q_count stays 4.
  - pc advances by 4 each cycle.
- redirect=1, redirect_pc=0x0000_0043 while 3 entries queued:
  - Next cycle: q_count=0, out_valid=0, iaddr=0x40.
  - Following cycle: out_valid=1, out_pc=0x40.
- Start from RESET_PC=0xFFFF_FFF8:
  - pc wraps 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Assert reset with queue full and redirect=1 in the same cycle:
  - Next cycle: q_count=0, out_valid=0, iaddr=RESET_PC (redirect ignored).
